// File: rtl/lstm_act_pkg.sv
// lstm_act_pkg: mode codes and PLAN breakpoint/offset constants for the activation unit
package lstm_act_pkg;
  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH = 1'b1;
  typedef struct packed {
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] b3;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] o3;
    logic [31:0] o4;
  } plan_t;
  function automatic plan_t plan_consts(input int fl);
    plan_t p;
    p.b1 = 32'd1 << fl;
    p.b2 = 32'd19 << (fl - 3);
    p.b3 = 32'd5 << fl;
    p.o1 = 32'd1 << (fl - 1);
    p.o2 = 32'd5 << (fl - 3);
    p.o3 = 32'd27 << (fl - 5);
    p.o4 = 32'd1 << fl;
    return p;
  endfunction
endpackage

// File: rtl/lstm_act_lane.sv
// lstm_act_lane: one-lane 3-stage sigmoid/tanh PLAN datapath
module lstm_act_lane
  import lstm_act_pkg::*;
#(
  parameter int D_WL = 16,
  parameter int D_FL = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2:0]      ld,
  input  logic            mode,
  input  logic [D_WL-1:0] x,
  output logic [D_WL-1:0] d_o
);
  localparam int AW = D_WL + 2;
  localparam plan_t P = plan_consts(D_FL);
  localparam logic [AW-1:0] ONE = AW'(P.b1);
  localparam logic [AW-1:0] BRK = AW'(P.b2);
  localparam logic [AW-1:0] FIVE = AW'(P.b3);
  localparam logic [AW-1:0] OF1 = AW'(P.o1);
  localparam logic [AW-1:0] OF2 = AW'(P.o2);
  localparam logic [AW-1:0] OF3 = AW'(P.o3);
  localparam logic [AW-1:0] ONE_R = AW'(P.o4);
  logic s1_q, s1_d, m1_q, m1_d, s2_q, s2_d, m2_q, m2_d;
  logic [AW-1:0] a1_q, a1_d, y2_q, y2_d, xe, mag, dbl, y2, t3, r3;
  logic [D_WL-1:0] d3_q, d3_d;
  always_comb begin
    xe = {{2{x[D_WL-1]}}, x};
    mag = x[D_WL-1] ? -xe : xe;
    dbl = (mode == ACT_TANH) ? mag << 1 : mag;
    s1_d = (en && ld[0]) ? x[D_WL-1] : s1_q;
    m1_d = (en && ld[0]) ? mode : m1_q;
    a1_d = (en && ld[0]) ? ((dbl >= FIVE) ? FIVE : dbl) : a1_q;
    y2 = (a1_q >= FIVE) ? ONE :
         (a1_q >= BRK)  ? (a1_q >> 5) + OF3 :
         (a1_q >= ONE)  ? (a1_q >> 3) + OF2 : (a1_q >> 2) + OF1;
    s2_d = (en && ld[1]) ? s1_q : s2_q;
    m2_d = (en && ld[1]) ? m1_q : m2_q;
    y2_d = (en && ld[1]) ? y2 : y2_q;
    t3 = (y2_q << 1) - ONE_R;
    r3 = (m2_q == ACT_TANH) ? (s2_q ? -t3 : t3) : (s2_q ? ONE_R - y2_q : y2_q);
    d3_d = (en && ld[2]) ? D_WL'(r3) : d3_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      m1_q <= 1'b0;
      a1_q <= '0;
      s2_q <= 1'b0;
      m2_q <= 1'b0;
      y2_q <= '0;
      d3_q <= '0;
    end else begin
      s1_q <= s1_d;
      m1_q <= m1_d;
      a1_q <= a1_d;
      s2_q <= s2_d;
      m2_q <= m2_d;
      y2_q <= y2_d;
      d3_q <= d3_d;
    end
  end
  assign d_o = d3_q;
endmodule

// File: rtl/lstm_act_pwl.sv
// lstm_act_pwl: multi-lane sigmoid/tanh activation, 3-stage pipeline with valid/ready backpressure
module lstm_act_pwl
  import lstm_act_pkg::*;
#(
  parameter int D_WL = 16,
  parameter int D_FL = 12,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*D_WL-1:0] x,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last,
  output logic [LANES*D_WL-1:0] d_o,
  output logic                  busy
);
  logic stall, en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
  assign stall = v3_q && !o_ready;
  assign en = !stall;
  assign in_ready = en;
  assign o_valid = v3_q;
  assign o_last = l3_q;
  assign busy = v1_q || v2_q || v3_q;
  // a stall freezes every stage, so bubbles keep their slots
  always_comb begin
    v1_d = en ? in_valid : v1_q;
    v2_d = en ? v1_q : v2_q;
    v3_d = en ? v2_q : v3_q;
    l1_d = en ? (in_valid && in_last) : l1_q;
    l2_d = en ? l1_q : l2_q;
    l3_d = en ? l2_q : l3_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
      l3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lstm_act_lane #(.D_WL(D_WL), .D_FL(D_FL)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .ld   ({v2_q, v1_q, in_valid}),
      .mode (mode),
      .x    (x[i*D_WL +: D_WL]),
      .d_o  (d_o[i*D_WL +: D_WL])
    );
  end
endmodule

// File: tb/tb_lstm_act_pwl.sv
// tb_lstm_act_pwl: table vectors, handshake sequences and random stream against a reference model
module tb_lstm_act_pwl;
  localparam int FL = 12;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0, in_last = 1'b0, o_ready = 1'b1;
  logic in_ready, o_valid, o_last, busy;
  logic [63:0] x = '0, d_o;
  int errors = 0, checks = 0, acc_cnt = 0, out_cnt = 0;
  logic [64:0] exp_q[$];
  logic [63:0] bx[256];
  logic bm[256], bl[256];
  typedef struct { logic m; logic [63:0] xv; logic [63:0] ev; } vec_t;
  vec_t tv[8];

  lstm_act_pwl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .x(x), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .d_o(d_o), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_act(input logic [15:0] xv, input logic m);
    int one = 1 << FL;
    int v = $signed(xv);
    int a = (v < 0) ? -v : v;
    int y, r;
    if (m) a = 2 * a;
    if (a >= 5 * one) y = one;
    else if (a * 8 >= 19 * one) y = a / 32 + 27 * one / 32;
    else if (a >= one) y = a / 8 + 5 * one / 8;
    else y = a / 4 + one / 2;
    if (m) r = (v < 0) ? -(2 * y - one) : 2 * y - one;
    else r = (v < 0) ? one - y : y;
    return 16'(r);
  endfunction

  function automatic logic [63:0] ref_beat(input logic [63:0] xv, input logic m);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = ref_act(xv[i*16 +: 16], m);
    return r;
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) begin
      exp_q.push_back({in_last, ref_beat(x, mode)});
      acc_cnt++;
    end
    if (o_valid && o_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_beat", {o_last, d_o}, 65'h0);
      else chk("sb_beat", {o_last, d_o}, exp_q.pop_front());
    end
  end

  task automatic run_stream(input int n, input int maxcyc);
    int k = 0, c = 0;
    logic acc;
    while (k < n && c < maxcyc) begin
      in_valid = 1'b1; mode = bm[k]; x = bx[k]; in_last = bl[k];
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      c++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("stream_all_accepted", 65'(k), 65'(n));
  endtask

  task automatic drain(input int maxcyc);
    int c = 0;
    while (exp_q.size() != 0 && c < maxcyc) begin @(posedge clk); #1; c++; end
    chk("drain_empty", 65'(exp_q.size()), 65'h0);
  endtask

  initial begin
    logic [63:0] held;
    int a0, o0;
    bit done;
    tv[0] = '{1'b0, {16'h6000, 16'hF000, 16'h1000, 16'h0000}, {16'h1000, 16'h0400, 16'h0C00, 16'h0800}};
    tv[1] = '{1'b1, {16'h8000, 16'hF000, 16'h1000, 16'h0000}, {16'hF000, 16'hF400, 16'h0C00, 16'h0000}};
    tv[2] = '{1'b0, {4{16'h1000}}, {4{16'h0C00}}};
    tv[3] = '{1'b1, {4{16'h1000}}, {4{16'h0C00}}};
    tv[4] = '{1'b0, {4{16'hF000}}, {4{16'h0400}}};
    tv[5] = '{1'b1, {4{16'hF000}}, {4{16'hF400}}};
    tv[6] = '{1'b0, {16'h5000, 16'h2600, 16'h25FF, 16'h8000}, {16'h1000, 16'h0EB0, 16'h0EBF, 16'h0000}};
    tv[7] = '{1'b1, {16'h7FFF, 16'h0FFF, 16'hF001, 16'h0001}, {16'h1000, 16'h0BFE, 16'hF402, 16'h0000}};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_o_valid", 65'(o_valid), 65'h0);
    chk("rst_d_o", 65'(d_o), 65'h0);
    chk("rst_in_ready", 65'(in_ready), 65'h1);
    chk("rst_busy", 65'(busy), 65'h0);
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1; mode = tv[t].m; x = tv[t].xv;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 chk("lat_early", 65'(o_valid), 65'h0);
      @(posedge clk); #1 chk("lat_valid", 65'(o_valid), 65'h1);
      chk($sformatf("vec%0d", t), 65'(d_o), 65'(tv[t].ev));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) begin
      bm[k] = k[0]; bx[k] = (k < 4) ? {4{16'h1000}} : {4{16'hF000}}; bl[k] = (k == 7);
    end
    run_stream(8, 20);
    drain(10);
    // five beats against a blocked output: only three fit
    o_ready = 1'b0;
    a0 = acc_cnt; o0 = out_cnt; done = 0;
    for (int k = 0; k < 5; k++) begin
      bm[k] = k[0]; bx[k] = {4{16'(k * 16'h0900)}}; bl[k] = (k == 4);
    end
    fork
      begin run_stream(5, 40); done = 1; end
      begin
        repeat (8) @(posedge clk);
        #2;
        chk("bp_accepted", 65'(acc_cnt - a0), 65'd3);
        chk("bp_in_ready", 65'(in_ready), 65'h0);
        chk("bp_busy", 65'(busy), 65'h1);
        held = d_o;
        repeat (2) @(posedge clk);
        #2 chk("bp_hold", 65'(d_o), 65'(held));
        o_ready = 1'b1;
      end
    join
    drain(20);
    chk("bp_out_count", 65'(out_cnt - o0), 65'd5);
    // randomized stream with random backpressure
    for (int k = 0; k < 200; k++) begin
      bm[k] = 1'($urandom); bx[k] = {$urandom, $urandom}; bl[k] = ($urandom_range(0, 3) == 0);
    end
    done = 0;
    fork
      begin run_stream(200, 3000); done = 1; end
      while (!done) begin @(posedge clk); #1 o_ready = ($urandom_range(0, 2) != 0); end
    join
    o_ready = 1'b1;
    drain(20);
    chk("rand_count", 65'(out_cnt), 65'(acc_cnt));
    bm[0] = 0; bm[1] = 1; bx[0] = {4{16'h1000}}; bx[1] = {4{16'hF000}}; bl[0] = 0; bl[1] = 1;
    run_stream(2, 10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_o_valid", 65'(o_valid), 65'h0);
    chk("mid_rst_busy", 65'(busy), 65'h0);
    exp_q.delete();
    rst_n = 1'b1;
    o0 = out_cnt;
    repeat (6) @(posedge clk);
    #1 chk("mid_rst_no_stale", 65'(out_cnt - o0), 65'h0);
    chk("mid_rst_o_valid_after", 65'(o_valid), 65'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
